// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants for the tri-state register bus reader
package mem_bus_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    // Widest select vector supported; consumers slice the low bits
    localparam int MAX_SOURCES = 64;
    localparam logic [MAX_SOURCES-1:0] CS_IDLE = '1;

    // Settle counter width covers the legal SettleCycles range 0..15
    localparam int CNT_BITS = 4;

    // Default build widths
    localparam int DEF_NR_OF_BITS      = 32;
    localparam int DEF_NR_OF_SOURCES   = 4;
    localparam int DEF_SEL_BITS        = 2;
    localparam int DEF_SETTLE_CYCLES   = 1;

endpackage

// File: rtl/mem_bus_sel_decode.sv
// rtl/mem_bus_sel_decode.sv - source index to one-cold select plus out-of-range flag
module mem_bus_sel_decode
    import mem_bus_pkg::*;
#(
    parameter int NrOfSources = DEF_NR_OF_SOURCES,
    parameter int SelBits     = DEF_SEL_BITS
) (
    input  logic [SelBits-1:0]     sel,
    output logic [NrOfSources-1:0] cs_n,
    output logic                   out_of_range
);

    // At most one bit is cleared; an unmatched index leaves the bus idle
    always_comb begin
        cs_n         = '1;
        out_of_range = 1'b1;
        for (int i = 0; i < NrOfSources; i++) begin
            if (sel == SelBits'(i)) begin
                cs_n[i]      = 1'b0;
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_reader.sv
// rtl/mem_bus_reader.sv - initiator that selects one bus source, waits, captures and responds
// Optional: define MEM_BUS_READER_BACKTOBACK_EN to launch a new read straight from RESP.
module mem_bus_reader
    import mem_bus_pkg::*;
#(
    parameter int NrOfBits     = DEF_NR_OF_BITS,
    parameter int NrOfSources  = DEF_NR_OF_SOURCES,
    parameter int SelBits      = DEF_SEL_BITS,
    parameter int SettleCycles = DEF_SETTLE_CYCLES
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEnable,
    input  logic                   Tick,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [SelBits-1:0]     ReqSel,
    input  logic [NrOfBits-1:0]    BusD,
    output logic [NrOfSources-1:0] cs,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic [NrOfBits-1:0]    RspData,
    output logic                   RspErr
);

    localparam logic [NrOfSources-1:0] CsIdle     = CS_IDLE[NrOfSources-1:0];
    localparam logic [CNT_BITS-1:0]    SettleLoad = CNT_BITS'(SettleCycles);

    logic [1:0]             state_q;
    logic [NrOfSources-1:0] cs_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [NrOfBits-1:0]    data_q;
    logic                   err_q;
    logic                   valid_q;
    logic                   ready_q;

    logic                   en;
    logic                   resp_exit;
    logic                   launch;
    logic [NrOfSources-1:0] dec_cs;
    logic                   dec_oor;

    mem_bus_sel_decode #(
        .NrOfSources (NrOfSources),
        .SelBits     (SelBits)
    ) u_decode (
        .sel          (ReqSel),
        .cs_n         (dec_cs),
        .out_of_range (dec_oor)
    );

    assign en        = ClockEnable & Tick;
    assign resp_exit = (state_q == RESP) & RspReady;

`ifdef MEM_BUS_READER_BACKTOBACK_EN
    // A response being accepted frees the block for a new request on the same edge
    assign launch   = en & ReqValid & ((state_q == IDLE) | resp_exit);
    assign ReqReady = ready_q | resp_exit;
`else
    assign launch   = en & ReqValid & (state_q == IDLE);
    assign ReqReady = ready_q;
`endif

    // Read sequencer: state moves first, then a launch overrides the next state
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cs_q    <= CsIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                SETTLE: begin
                    if (en) begin
                        if (cnt_q == '0) begin
                            state_q <= CAPTURE;
                        end else begin
                            cnt_q <= cnt_q - CNT_BITS'(1);
                        end
                    end
                end
                CAPTURE: begin
                    // Select is still low on this edge, so BusD is the selected source
                    if (en) begin
                        data_q  <= BusD;
                        err_q   <= 1'b0;
                        cs_q    <= CsIdle;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Acceptance is deliberately independent of the enable
                    if (RspReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (launch) begin
                ready_q <= 1'b0;
                if (dec_oor) begin
                    // No bus access for a missing source; respond with an error
                    state_q <= RESP;
                    data_q  <= '0;
                    err_q   <= 1'b1;
                    valid_q <= 1'b1;
                end else begin
                    state_q <= SETTLE;
                    cs_q    <= dec_cs;
                    cnt_q   <= SettleLoad;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign cs       = cs_q;
    assign RspValid = valid_q;
    assign RspData  = data_q;
    assign RspErr   = err_q;

endmodule

// File: tb/tb_mem_bus_reader.sv
// tb/tb_mem_bus_reader.sv - directed self-checking bench for mem_bus_reader
module tb_mem_bus_reader;

    logic        clk;
    logic        rstn;
    logic        ce;
    logic        tick;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic [31:0] bus_d;
    logic [3:0]  cs;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        req_valid3;
    logic        req_ready3;
    logic [1:0]  req_sel3;
    logic [31:0] bus_d3;
    logic [2:0]  cs3;
    logic        rsp_valid3;
    logic        rsp_ready3;
    logic [31:0] rsp_data3;
    logic        rsp_err3;

    int total;
    int bad;

    mem_bus_reader #(
        .NrOfBits(32), .NrOfSources(4), .SelBits(2), .SettleCycles(1)
    ) u_dut (
        .Clock(clk), .Reset(rstn), .ClockEnable(ce), .Tick(tick),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqSel(req_sel),
        .BusD(bus_d), .cs(cs),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data), .RspErr(rsp_err)
    );

    mem_bus_reader #(
        .NrOfBits(32), .NrOfSources(3), .SelBits(2), .SettleCycles(1)
    ) u_dut3 (
        .Clock(clk), .Reset(rstn), .ClockEnable(ce), .Tick(tick),
        .ReqValid(req_valid3), .ReqReady(req_ready3), .ReqSel(req_sel3),
        .BusD(bus_d3), .cs(cs3),
        .RspValid(rsp_valid3), .RspReady(rsp_ready3), .RspData(rsp_data3), .RspErr(rsp_err3)
    );

    function automatic logic [31:0] src_val(input int i);
        case (i)
            0:       return 32'h1111_0000;
            1:       return 32'h2222_1111;
            2:       return 32'hDEAD_BEEF;
            default: return 32'h3333_CAFE;
        endcase
    endfunction

    // Bus model: the source whose select is low drives; idle bus reads as pulled up
    always_comb begin
        bus_d = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (!cs[i]) bus_d = src_val(i);
        end
    end

    assign bus_d3 = (cs3 != 3'b111) ? 32'hA5A5_A5A5 : 32'hFFFF_FFFF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp3(output int n);
        n = 0;
        while (!rsp_valid3 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int got_rsp;
        total      = 0;
        bad        = 0;
        rstn       = 1'b0;
        ce         = 1'b1;
        tick       = 1'b1;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        rsp_ready  = 1'b0;
        req_valid3 = 1'b0;
        req_sel3   = 2'd0;
        rsp_ready3 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cs", 64'(cs), 64'hF);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_cs3", 64'(cs3), 64'h7);
        rstn = 1'b1;
        @(negedge clk);

        // Basic read of source 2: select low for 3 cycles, response after 3 edges past accept
        req_sel   = 2'd2;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_req_ready_busy", 64'(req_ready), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("rd_cs_k%0d", k), 64'(cs), (k < 4) ? 64'hB : 64'hF);
            check($sformatf("rd_valid_k%0d", k), 64'(rsp_valid), (k == 4) ? 64'd1 : 64'd0);
        end
        check("rd_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check("rd_err", 64'(rsp_err), 64'd0);

        // Backpressure: response held, new requests ignored
        req_valid = 1'b1;
        req_sel   = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k), 64'(rsp_valid), 64'd1);
            check($sformatf("bp_data_%0d", k), 64'(rsp_data), 64'hDEAD_BEEF);
            check($sformatf("bp_cs_%0d", k), 64'(cs), 64'hF);
            check($sformatf("bp_req_ready_%0d", k), 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_released_valid", 64'(rsp_valid), 64'd0);
        check("bp_idle_ready", 64'(req_ready), 64'd1);

        // Tick gating: only every third edge is enabled after the accept edge
        req_sel   = 2'd1;
        req_valid = 1'b1;
        tick      = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 9; c++) begin
            req_valid = 1'b0;
            tick      = (c % 3 == 0);
            @(negedge clk);
            check($sformatf("tk_cs_%0d", c), 64'(cs), (c >= 9) ? 64'hF : 64'hD);
            check($sformatf("tk_valid_%0d", c), 64'(rsp_valid), (c >= 9) ? 64'd1 : 64'd0);
        end
        check("tk_data", 64'(rsp_data), 64'h2222_1111);
        tick      = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during SETTLE abandons the read and releases the select
        req_sel   = 2'd3;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mr_cs_settle", 64'(cs), 64'h7);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mr_cs_reset", 64'(cs), 64'hF);
        check("mr_ready_reset", 64'(req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mr_no_rsp_%0d", k), 64'(rsp_valid), 64'd0);
        end

        // Out-of-range index on the 3-source instance: no bus access, error response
        req_sel3   = 2'd3;
        req_valid3 = 1'b1;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("inv_cs3", 64'(cs3), 64'h7);
        check("inv_valid3", 64'(rsp_valid3), 64'd1);
        check("inv_err3", 64'(rsp_err3), 64'd1);
        check("inv_data3", 64'(rsp_data3), 64'd0);
        rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;
        check("inv_released3", 64'(rsp_valid3), 64'd0);

        // Valid read on the 3-source instance clears the error flag
        req_sel3   = 2'd0;
        req_valid3 = 1'b1;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("ok3_cs_low", 64'(cs3), 64'h6);
        wait_rsp3(n);
        check("ok3_latency", 64'(n), 64'd3);
        check("ok3_data", 64'(rsp_data3), 64'hA5A5_A5A5);
        check("ok3_err", 64'(rsp_err3), 64'd0);
        check("ok3_cs_idle", 64'(cs3), 64'h7);
        rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;

`ifdef MEM_BUS_READER_BACKTOBACK_EN
        // Back-to-back reads of sources 0..3 with the response always accepted
        got_rsp   = 0;
        rsp_ready = 1'b1;
        req_sel   = 2'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && got_rsp < 4; k++) begin
            @(negedge clk);
            check($sformatf("b2b_onecold_%0d", k), 64'($countones(~cs) <= 1), 64'd1);
            if (rsp_valid) begin
                check($sformatf("b2b_data_%0d", got_rsp), 64'(rsp_data), 64'(src_val(got_rsp)));
                got_rsp++;
                if (got_rsp < 4) req_sel = 2'(got_rsp);
                else req_valid = 1'b0;
            end
        end
        check("b2b_count", 64'(got_rsp), 64'd4);
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("b2b_idle", 64'(rsp_valid), 64'd0);
`else
        got_rsp = 0;
        // Without back-to-back, a request presented in RESP is not taken
        req_sel   = 2'd0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check("nb_first_valid", 64'(rsp_valid), 64'd1);
        check("nb_ready_in_resp", 64'(req_ready), 64'd0);
        req_sel   = 2'd1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("nb_idle_gap_cs", 64'(cs), 64'hF);
        check("nb_idle_gap_ready", 64'(req_ready), 64'd1);
        check("nb_count", 64'(got_rsp), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
